// File: rtl/m_kitchen_timer_core_pkg.sv
// Shared types and BCD helpers for the kitchen timer core.
package m_kitchen_timer_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h99;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        return v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == 8'h00)
            return max;
        if (v[3:0] == 4'h0)
            return {v[7:4] - 4'h1, 4'h9};
        return v - 8'h01;
    endfunction

endpackage

// File: rtl/m_kitchen_timer_core_bcd_pair_updown.sv
// Two-digit BCD up/down counter wrapping between 00 and MAXVAL.
module m_bcd_pair_updown
    import m_kitchen_timer_core_pkg::*;
#(
    parameter logic [7:0] MAXVAL = 8'h59
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] q,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (!n_reset)
            q <= 8'h00;
        else if (clr)
            q <= 8'h00;
        else if (inc)
            q <= bcd_inc(q, MAXVAL);
        else if (dec)
            q <= bcd_dec(q, MAXVAL);
    end

    // A decrement while zero is a borrow into the next pair
    assign zero = (q == 8'h00);

endmodule

// File: rtl/m_kitchen_timer_core.sv
// Minutes:seconds BCD countdown engine with start/pause, clear and alarm.
module m_kitchen_timer_core
    import m_kitchen_timer_core_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       alarm,
    output logic       colon
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);
    localparam logic [AW-1:0] A_LAST = AW'(ALARM_SECS - 1);

    state_t        state, nstate;
    logic [PW-1:0] presc, npresc;
    logic [AW-1:0] acnt, nacnt;
    logic [3:0]    hist;
    logic          e_min, e_sec, e_start, e_clr;
    logic          tick, sec_zero, min_zero, cnt_zero;
    logic          sec_clr, sec_inc, sec_dec;
    logic          min_clr, min_inc, min_dec;

    assign e_min   = btn_min & ~hist[3];
    assign e_sec   = btn_sec & ~hist[2];
    assign e_start = btn_start & ~hist[1];
    assign e_clr   = btn_clear & ~hist[0];
    assign tick    = (presc == P_LAST);
    assign cnt_zero = sec_zero & min_zero;
    assign min_dec = sec_dec & sec_zero & (state == RUN);
    assign min_clr = sec_clr;

    always_comb begin
        nstate  = state;
        npresc  = '0;
        nacnt   = '0;
        sec_clr = 1'b0;
        sec_inc = 1'b0;
        sec_dec = 1'b0;
        min_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (e_clr)
                    sec_clr = 1'b1;
                else if (e_start) begin
                    if (!cnt_zero)
                        nstate = RUN;
                end else begin
                    sec_inc = e_sec;
                    min_inc = e_min;
                end
            end
            RUN: begin
                if (e_clr) begin
                    nstate  = IDLE;
                    sec_clr = 1'b1;
                end else if (e_start)
                    nstate = IDLE;
                else if (tick) begin
                    sec_dec = 1'b1;
                    if (min_zero && sec_bcd == 8'h01)
                        nstate = ALARM;
                end else
                    npresc = presc + 1'b1;
            end
            ALARM: begin
                if (e_clr || e_start)
                    nstate = IDLE;
                else if (tick) begin
                    if (acnt == A_LAST)
                        nstate = IDLE;
                    else
                        nacnt = acnt + 1'b1;
                end else begin
                    npresc = presc + 1'b1;
                    nacnt  = acnt;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state   <= IDLE;
            presc   <= '0;
            acnt    <= '0;
            hist    <= 4'hF;
            running <= 1'b0;
            alarm   <= 1'b0;
            colon   <= 1'b1;
        end else begin
            state   <= nstate;
            presc   <= npresc;
            acnt    <= nacnt;
            hist    <= {btn_min, btn_sec, btn_start, btn_clear};
            running <= (nstate == RUN);
            alarm   <= (nstate == ALARM);
            colon   <= (nstate == IDLE) ||
                       (nstate == RUN && npresc < P_HALF);
        end
    end

    m_bcd_pair_updown #(.MAXVAL(SEC_MAX)) u_sec (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (sec_clr),
        .inc     (sec_inc),
        .dec     (sec_dec),
        .q       (sec_bcd),
        .zero    (sec_zero)
    );

    m_bcd_pair_updown #(.MAXVAL(MIN_MAX)) u_min (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (min_clr),
        .inc     (min_inc),
        .dec     (min_dec),
        .q       (min_bcd),
        .zero    (min_zero)
    );

endmodule

// File: tb/tb_m_kitchen_timer_core.sv
// Scoreboard bench: cycle-level reference model vs m_kitchen_timer_core.
module tb_m_kitchen_timer_core;

    localparam int TD = 10;
    localparam int AS = 3;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_ALARM = 2;

    typedef struct {
        logic [7:0] mn;
        logic [7:0] sc;
        logic       run;
        logic       alm;
        logic       col;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, alarm, colon;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    // reference model: plain integers, total-seconds countdown
    int   m_mins = 0, m_secs = 0, m_mode = M_IDLE;
    int   m_phase = 0, m_aleft = 0;
    logic [3:0] m_prev = 4'hF;

    always #5 clk = ~clk;

    m_kitchen_timer_core #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .btn_min   (btn_min),
        .btn_sec   (btn_sec),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .running   (running),
        .alarm     (alarm),
        .colon     (colon)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic model_step(input logic rn, input logic [3:0] b);
        logic [3:0] e;
        int t;
        if (!rn) begin
            m_mins = 0; m_secs = 0; m_mode = M_IDLE;
            m_phase = 0; m_aleft = 0; m_prev = 4'hF;
            return;
        end
        e = b & ~m_prev;
        m_prev = b;
        // e = {min, sec, start, clear}
        if (m_mode == M_IDLE) begin
            if (e[0]) begin
                m_mins = 0; m_secs = 0;
            end else if (e[1]) begin
                if (m_mins != 0 || m_secs != 0) begin
                    m_mode = M_RUN; m_phase = 0;
                end
            end else begin
                if (e[3]) m_mins = (m_mins + 1) % 100;
                if (e[2]) m_secs = (m_secs + 1) % 60;
            end
        end else if (m_mode == M_RUN) begin
            if (e[0]) begin
                m_mode = M_IDLE; m_mins = 0; m_secs = 0;
            end else if (e[1]) begin
                m_mode = M_IDLE;
            end else begin
                m_phase++;
                if (m_phase == TD) begin
                    m_phase = 0;
                    t = m_mins * 60 + m_secs - 1;
                    m_mins = t / 60;
                    m_secs = t % 60;
                    if (t == 0) begin
                        m_mode = M_ALARM;
                        m_aleft = AS * TD;
                    end
                end
            end
        end else begin
            if (e[0] || e[1])
                m_mode = M_IDLE;
            else begin
                m_aleft--;
                if (m_aleft == 0) m_mode = M_IDLE;
            end
        end
    endtask

    task automatic cycle(input logic rn, input logic [3:0] b);
        exp_t x;
        @(negedge clk);
        n_reset   = rn;
        btn_min   = b[3];
        btn_sec   = b[2];
        btn_start = b[1];
        btn_clear = b[0];
        model_step(rn, b);
        x.mn  = to_bcd(m_mins);
        x.sc  = to_bcd(m_secs);
        x.run = (m_mode == M_RUN);
        x.alm = (m_mode == M_ALARM);
        x.col = (m_mode == M_IDLE) ||
                (m_mode == M_RUN && m_phase < TD / 2);
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 4'b0000);
    endtask

    task automatic press(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, b);
            cycle(1'b1, 4'b0000);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h",
                     nm, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("min_bcd", min_bcd, x.mn);
            chk("sec_bcd", sec_bcd, x.sc);
            chk("running", {7'd0, running}, {7'd0, x.run});
            chk("alarm",   {7'd0, alarm},   {7'd0, x.alm});
            chk("colon",   {7'd0, colon},   {7'd0, x.col});
            n_chk++;
            if (running && alarm) begin
                n_fail++;
                $display("FAIL run_alarm_excl: running=1 alarm=1");
            end
        end
    end

    initial begin
        logic [3:0] lv;
        // reset with start held, then release while still held
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0010);
        idle(2);
        press(4'b0010, 1);
        idle(2);
        // set 03:01 via 3 min and 61 sec pulses
        press(4'b1000, 3);
        press(4'b0100, 61);
        idle(2);
        press(4'b0001, 1);
        // 01:00 countdown and colon blink
        press(4'b1000, 1);
        press(4'b0010, 1);
        idle(25);
        press(4'b0010, 1);
        press(4'b0001, 1);
        // 00:02 to alarm and alarm timeout
        press(4'b0100, 2);
        press(4'b0010, 1);
        idle(55);
        // same with early acknowledge
        press(4'b0100, 2);
        cycle(1'b1, 4'b0010);
        idle(23);
        press(4'b0010, 1);
        idle(5);
        // 00:40: start+clear together, then start at zero
        press(4'b0100, 40);
        press(4'b0010, 1);
        idle(3);
        press(4'b0011, 1);
        press(4'b0010, 1);
        idle(3);
        // min during run is ignored
        press(4'b0100, 40);
        press(4'b0010, 1);
        press(4'b1000, 2);
        idle(12);
        press(4'b0010, 1);
        press(4'b0001, 1);
        // reset mid-countdown at 05:17
        press(4'b1000, 5);
        press(4'b0100, 17);
        press(4'b0010, 1);
        idle(7);
        cycle(1'b0, 4'b0000);
        idle(3);
        // minutes wrap 99 -> 00, seconds wrap 59 -> 00
        press(4'b1000, 100);
        press(4'b0100, 60);
        idle(2);
        // randomized traffic
        lv = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) lv[3] = ~lv[3];
            if ($urandom_range(0, 5) == 0) lv[2] = ~lv[2];
            if ($urandom_range(0, 40) == 0) lv[1] = ~lv[1];
            if ($urandom_range(0, 150) == 0) lv[0] = ~lv[0];
            cycle($urandom_range(0, 499) != 0, lv);
        end
        idle(2);
        @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
